// File: rtl/reg_dump_uart.sv
// Register-file dump over UART: walks x0..x31 and prints each value as an ASCII hex line (8N1).
// Build macro REG_DUMP_HDR_EN adds an "xNN:" prefix to every line.
module reg_dump_uart #(
  parameter int CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef REG_DUMP_HDR_EN
  localparam logic [3:0] LINE_LEN = 4'd13;
  localparam logic [3:0] HEX_BASE = 4'd4;
`else
  localparam logic [3:0] LINE_LEN = 4'd9;
  localparam logic [3:0] HEX_BASE = 4'd0;
`endif
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

`ifdef REG_DUMP_HDR_EN
  // Returns {tens[1:0], ones[3:0]} of a register number 0..31.
  function automatic logic [5:0] dec_digits(input logic [4:0] n);
    logic [1:0] tens;
    if (n >= 5'd30)      tens = 2'd3;
    else if (n >= 5'd20) tens = 2'd2;
    else if (n >= 5'd10) tens = 2'd1;
    else                 tens = 2'd0;
    return {tens, 4'(n - 5'(tens) * 5'd10)};
  endfunction
`endif

  state_e      state_q, state_d;
  logic [4:0]  reg_sel_q, reg_sel_d;
  logic [31:0] snap_q, snap_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic        active_q, active_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tx_idle_s, line_loaded_s, last_reg_s, load_s;
  logic [2:0]  hex_idx_s;
  logic [7:0]  byte_s;

  assign tx_idle_s     = ~active_q;
  assign line_loaded_s = (byte_idx_q == LINE_LEN);
  assign last_reg_s    = (reg_sel_q == 5'd31);
  assign load_s        = (state_q == S_SEND) && !line_loaded_s && tx_idle_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      reg_sel_q  <= 5'd0;
      snap_q     <= 32'd0;
      byte_idx_q <= 4'd0;
      active_q   <= 1'b0;
      bit_q      <= 4'd0;
      div_q      <= 16'd0;
      shreg_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_sel_q  <= reg_sel_d;
      snap_q     <= snap_d;
      byte_idx_q <= byte_idx_d;
      active_q   <= active_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; a non-final line leaves SEND once its last byte is loaded, x31 waits for the line to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SEL; else state_d = S_IDLE;
      S_SEL:   state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
      S_SEND:  if (line_loaded_s && (!last_reg_s || tx_idle_s)) state_d = S_NEXT;
               else state_d = S_SEND;
      S_NEXT:  if (last_reg_s) state_d = S_FIN; else state_d = S_SEL;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Current line byte: hex digits MSB nibble first, optional header, newline last.
  always_comb begin
    hex_idx_s = 3'(byte_idx_q - HEX_BASE);
    case (byte_idx_q)
      LINE_LEN - 4'd1: byte_s = 8'h0A;
`ifdef REG_DUMP_HDR_EN
      4'd0:    byte_s = 8'h78;
      4'd1:    byte_s = 8'h30 + {6'd0, dec_digits(reg_sel_q)[5:4]};
      4'd2:    byte_s = 8'h30 + {4'd0, dec_digits(reg_sel_q)[3:0]};
      4'd3:    byte_s = 8'h3A;
`endif
      default: byte_s = hex_ascii(snap_q[{~hex_idx_s, 2'b00} +: 4]);
    endcase
  end

  // Register select, snapshot and byte index; reg_sel wraps 31 -> 0 so the next dump starts at x0.
  always_comb begin
    reg_sel_d  = reg_sel_q;
    snap_d     = snap_q;
    byte_idx_d = byte_idx_q;
    if (state_q == S_NEXT) reg_sel_d = reg_sel_q + 5'd1;
    else                   reg_sel_d = reg_sel_q;
    if (state_q == S_LATCH) begin
      snap_d     = reg_data;
      byte_idx_d = 4'd0;
    end else if (load_s) begin
      byte_idx_d = byte_idx_q + 4'd1;
    end else begin
      byte_idx_d = byte_idx_q;
    end
  end

  // UART transmitter: bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    div_d    = div_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    if (load_s) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      div_d    = 16'd0;
      shreg_d  = byte_s;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (div_q == DIV_MAX) begin
        div_d = 16'd0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else if (bit_q == 4'd8) begin
          bit_d = bit_q + 4'd1;
          tx_d  = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  // Status outputs decoded from the upcoming state so they are registered alongside it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_SEL, S_LATCH, S_SEND, S_NEXT: busy_d = 1'b1;
      S_FIN:   done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign reg_sel = reg_sel_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
